// File: rtl/core_type.sv
`default_nettype none
// ============================================================================
// core_type : shared constants and entry types for the core front end
// Rev 1.0
// ============================================================================
package core_type;

    localparam logic [31:0] ISTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] istr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/core_sync_fifo.sv
`default_nettype none
// ============================================================================
// core_sync_fifo : in-order synchronous FIFO with clear, count and head view
// Rev 1.0
// ============================================================================
module core_sync_fifo #(
    parameter type         T     = logic [31:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] cnt_o,
    output T                       head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;

    // Callers guarantee no push when full and no pop when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/core_if_istr_buf.sv
`default_nettype none
// ============================================================================
// core_if_istr_buf : IF-stage sequential fetcher and instruction queue to ID
// Rev 1.0
// ============================================================================
module core_if_istr_buf
    import core_type::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic        istr_valid,
    input  logic        istr_ready,
    output logic [31:0] istr,
    output logic [31:0] istr_pc
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned CW1     = CW + 1;
    localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   istr_pc_q;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic          stale_q, stale_d;
    logic [CW-1:0] fifo_cnt, fifo_cnt_d;
    fetch_entry_t  head, push_entry;
    logic          gnt_fire, push, pop, valid;

    assign gnt_fire   = req_q && ibus_gnt;
    assign valid      = (fifo_cnt != '0) && !flush;
    assign pop        = valid && istr_ready;
    assign push       = ibus_rvalid && (disc_q == '0) && !flush;
    assign push_entry = '{pc: resp_pc_q, istr: ibus_rdata};

    core_sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (flush),
        .push_i (push),
        .data_i (push_entry),
        .pop_i  (pop),
        .cnt_o  (fifo_cnt),
        .head_o (head)
    );

    always_comb begin
        out_d      = out_q + CW'(gnt_fire) - CW'(ibus_rvalid);
        fifo_cnt_d = fifo_cnt + CW'(push) - CW'(pop);
        disc_d     = disc_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        stale_d    = stale_q;
        req_d      = 1'b0;
        addr_d     = addr_q;

        if (ibus_rvalid && (disc_q != '0)) disc_d = disc_q - CW'(1);
        if (push) resp_pc_d = resp_pc_q + 32'd4;
        // A stale grant belongs to the pre-redirect stream and must not advance fetch_pc.
        if (gnt_fire) begin
            stale_d = 1'b0;
            if (!stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (flush) begin
            fifo_cnt_d = '0;
            fetch_pc_d = flush_pc;
            resp_pc_d  = flush_pc;
            stale_d    = req_q && !ibus_gnt;
            disc_d     = out_d + CW'(stale_d);
        end

        if (req_q && !ibus_gnt) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = (CW1'(fifo_cnt_d) + CW1'(out_d)) < DEPTH_W;
            addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            stale_q    <= 1'b0;
            istr_pc_q  <= '0;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            stale_q    <= stale_d;
            if (valid) istr_pc_q <= head.pc;
        end
    end

    assign ibus_req   = req_q;
    assign ibus_addr  = addr_q;
    assign istr_valid = valid;
    assign istr       = valid ? head.istr : ISTR_NOP;
    assign istr_pc    = valid ? head.pc : istr_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_core_if_istr_buf.sv
`default_nettype none
// ============================================================================
// tb_core_if_istr_buf : bus responder model plus scoreboard for the fetch buffer
// Rev 1.0
// ============================================================================
module tb_core_if_istr_buf;
    import core_type::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        flush       = 1'b0;
    logic [31:0] flush_pc    = '0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt    = 1'b0;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata  = '0;
    logic        istr_valid;
    logic        istr_ready  = 1'b0;
    logic [31:0] istr;
    logic [31:0] istr_pc;

    core_if_istr_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .ibus_req    (ibus_req),
        .ibus_addr   (ibus_addr),
        .ibus_gnt    (ibus_gnt),
        .ibus_rvalid (ibus_rvalid),
        .ibus_rdata  (ibus_rdata),
        .istr_valid  (istr_valid),
        .istr_ready  (istr_ready),
        .istr        (istr),
        .istr_pc     (istr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] pc; bit stale; int due; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] istr; } exp_t;

    infl_t       infl_q[$];
    exp_t        exp_q[$];
    infl_t       ne;
    exp_t        mx;
    int          checks = 0, failures = 0;
    int          gnt_delay = 0, lat = 1, cyc = 0, wcnt = 0, last_due = 0, npops = 0;
    logic [31:0] model_pc = RESET_PC;
    bit          stale_pend = 1'b0, prev_hold = 1'b0, arm_first = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] first_pc = 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Bus responder: grants, returns data in grant order, tracks redirect staleness.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (!rst_n) begin
            infl_q.delete();
            exp_q.delete();
            stale_pend  = 1'b0;
            model_pc    = RESET_PC;
            prev_hold   = 1'b0;
            wcnt        = 0;
            ibus_gnt    = 1'b0;
            ibus_rvalid = 1'b0;
        end else begin
            if (prev_hold) begin
                check("req_held", 32'(ibus_req), 32'd1);
                check("addr_held", ibus_addr, prev_addr);
            end
            ibus_gnt = 1'b0;
            if (ibus_req) begin
                if (wcnt < gnt_delay) begin
                    wcnt++;
                end else begin
                    wcnt     = 0;
                    ibus_gnt = 1'b1;
                    ne.addr  = ibus_addr;
                    ne.pc    = model_pc;
                    ne.stale = stale_pend;
                    if (stale_pend) begin
                        stale_pend = 1'b0;
                    end else begin
                        check("fetch_addr", ibus_addr, model_pc);
                        model_pc = model_pc + 32'd4;
                    end
                    ne.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                    last_due = ne.due;
                    infl_q.push_back(ne);
                    check("credit_ok", 32'(infl_q.size() + exp_q.size() <= int'(DEPTH)), 32'd1);
                end
            end
            if (flush) begin
                model_pc = flush_pc;
                foreach (infl_q[i]) infl_q[i].stale = 1'b1;
                exp_q.delete();
                if (ibus_req && !ibus_gnt) stale_pend = 1'b1;
                arm_first = 1'b1;
            end
            ibus_rvalid = 1'b0;
            ibus_rdata  = '0;
            if (infl_q.size() > 0 && infl_q[0].due <= cyc) begin
                ne          = infl_q.pop_front();
                ibus_rvalid = 1'b1;
                ibus_rdata  = ne.addr ^ KEY;
                if (!ne.stale) exp_q.push_back('{pc: ne.pc, istr: ne.pc ^ KEY});
            end
            prev_hold = ibus_req && !ibus_gnt;
            prev_addr = ibus_addr;
        end
    end

    // Monitor: every accepted instruction must be the oldest expected one.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (istr_valid && istr_ready) begin
                npops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_istr: got pc %h istr %h, none expected", istr_pc, istr);
                end else begin
                    mx = exp_q.pop_front();
                    check("istr_pc", istr_pc, mx.pc);
                    check("istr", istr, mx.istr);
                    if (arm_first) begin
                        first_pc  = istr_pc;
                        arm_first = 1'b0;
                    end
                end
            end else if (!istr_valid) begin
                check("istr_nop", istr, ISTR_NOP);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  n0;
        bit  found;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req", 32'(ibus_req), 32'd0);
        check("rst_addr", ibus_addr, RESET_PC);
        check("rst_valid", 32'(istr_valid), 32'd0);
        check("rst_istr", istr, ISTR_NOP);
        check("rst_pc", istr_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("first_req", 32'(ibus_req), 32'd1);
        check("first_addr", ibus_addr, RESET_PC);

        // Streaming at one instruction per cycle.
        istr_ready = 1'b1;
        repeat (10) @(negedge clk);
        n0 = npops;
        repeat (10) @(negedge clk);
        check("throughput", 32'(npops - n0), 32'd10);

        // Back-pressure fills the queue and stops fetching.
        istr_ready = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("stall_req", 32'(ibus_req), 32'd0);
        check("stall_fill", 32'(exp_q.size()), 32'(DEPTH));
        check("stall_inflight", 32'(infl_q.size()), 32'd0);
        istr_ready = 1'b1;
        @(negedge clk);
        #1;
        check("resume_req", 32'(ibus_req), 32'd1);

        // Slow grants: request must be held stable.
        gnt_delay = 3;
        repeat (16) @(negedge clk);
        gnt_delay = 0;

        // Redirect with responses in flight.
        lat = 3;
        repeat (12) @(negedge clk);
        flush     = 1'b1;
        flush_pc  = 32'h0000_0100;
        first_pc  = 32'hDEAD_BEEF;
        #1;
        check("flush_valid", 32'(istr_valid), 32'd0);
        check("inflight_at_flush", 32'(infl_q.size() >= 2), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        lat   = 1;
        repeat (12) @(negedge clk);
        check("flush_first_pc", first_pc, 32'h0000_0100);

        // Redirect while a request is pending ungranted.
        gnt_delay = 3;
        found     = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            #3;
            if (ibus_req && !ibus_gnt && wcnt == 1) found = 1'b1;
        end
        check("pending_found", 32'(found), 32'd1);
        @(negedge clk);
        flush    = 1'b1;
        flush_pc = 32'h0000_0100;
        first_pc = 32'hDEAD_BEEF;
        #1;
        check("pend_req_held", 32'(ibus_req), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        repeat (24) @(negedge clk);
        gnt_delay = 0;
        repeat (6) @(negedge clk);
        check("pend_first_pc", first_pc, 32'h0000_0100);

        // Redirect near the top of the address space to exercise wrap.
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFF8;
        first_pc = 32'hDEAD_BEEF;
        @(negedge clk);
        flush = 1'b0;
        repeat (12) @(negedge clk);
        check("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

        // Asynchronous reset with entries queued.
        istr_ready = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 3) found = 1'b1;
        end
        check("three_queued", 32'(found), 32'd1);
        @(negedge clk);
        #1;
        check("pre_reset_valid", 32'(istr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(istr_valid), 32'd0);
        check("arst_req", 32'(ibus_req), 32'd0);
        check("arst_istr", istr, ISTR_NOP);
        check("arst_pc", istr_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("restart_req", 32'(ibus_req), 32'd1);
        check("restart_addr", ibus_addr, RESET_PC);
        istr_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
